// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: memory-access FSM state encoding for the pipeline controller.
package lc3b_types;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_IND2 = 1'b1
    } lc3b_pctl_state;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: one-cycle registered count, holds at all-ones instead of wrapping.
// No flow control; synchronous active-high reset clears the count.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_control.sv
// LC-3b pipeline controller: stage loads/flushes and memory strobes, all combinational (zero latency).
// Any outstanding fetch or data access freezes every stage register; stalled cycles are counted.
module pipeline_control
    import lc3b_types::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   imem_resp,
    input  logic                   dmem_req,
    input  logic                   mem_is_store,
    input  logic                   mem_indirect,
    input  logic                   dmem_resp,
    input  logic                   load_use,
    input  logic                   branch_taken,
    output logic                   imem_read,
    output logic                   dmem_read,
    output logic                   dmem_write,
    output logic                   indir_phase,
    output logic                   load_pc,
    output logic                   load_if_id,
    output logic                   load_id_ex,
    output logic                   load_ex_mem,
    output logic                   load_mem_wb,
    output logic                   flush_if_id,
    output logic                   flush_id_ex,
    output logic                   flush_ex_mem,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    lc3b_pctl_state state, next_state;
    logic           access_done;
    logic           mem_stall;
    logic           fetch_ok;
    logic           global_stall;
    logic           imem_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Indirect accesses take two data-memory round trips: pointer read, then the real access.
    always_comb begin
        next_state  = state;
        dmem_read   = 1'b0;
        dmem_write  = 1'b0;
        indir_phase = 1'b0;
        access_done = 1'b0;
        case (state)
            S_RUN: begin
                if (dmem_req) begin
                    dmem_read  = !mem_is_store | mem_indirect;
                    dmem_write = mem_is_store & !mem_indirect;
                    if (dmem_resp) begin
                        if (mem_indirect) begin
                            next_state = S_IND2;
                        end else begin
                            access_done = 1'b1;
                        end
                    end
                end
            end
            S_IND2: begin
                indir_phase = 1'b1;
                if (dmem_req) begin
                    dmem_read  = !mem_is_store;
                    dmem_write = mem_is_store;
                    if (dmem_resp) begin
                        next_state  = S_RUN;
                        access_done = 1'b1;
                    end
                end
            end
            default: next_state = S_RUN;
        endcase
        if (reset) begin
            dmem_read   = 1'b0;
            dmem_write  = 1'b0;
            indir_phase = 1'b0;
        end
    end

    assign mem_stall    = dmem_req & !access_done;
    assign fetch_ok     = imem_resp | imem_done_q;
    assign global_stall = mem_stall | !fetch_ok;
    assign imem_read    = !fetch_ok & !reset;

    // Remember a fetch that completed while the pipe was frozen so it is not re-requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_done_q <= 1'b0;
        end else if (!global_stall) begin
            imem_done_q <= 1'b0;
        end else if (imem_resp) begin
            imem_done_q <= 1'b1;
        end
    end

    always_comb begin
        load_pc      = 1'b0;
        load_if_id   = 1'b0;
        load_id_ex   = 1'b0;
        load_ex_mem  = 1'b0;
        load_mem_wb  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (reset) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (!global_stall) begin
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            if (branch_taken) begin
                load_pc      = 1'b1;
                load_if_id   = 1'b1;
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end else if (load_use) begin
                flush_id_ex = 1'b1;
            end else begin
                load_pc    = 1'b1;
                load_if_id = 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH(STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (global_stall & !reset),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: vector table from a reset state plus multi-cycle memory sequences.
module tb_pipeline_control;

    logic clk = 1'b0;
    logic reset;
    logic imem_resp, dmem_req, mem_is_store, mem_indirect, dmem_resp, load_use, branch_taken;
    logic imem_read, dmem_read, dmem_write, indir_phase;
    logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic flush_if_id, flush_id_ex, flush_ex_mem;
    logic [15:0] stall_cycles;
    logic imem_read4, dmem_read4, dmem_write4, indir_phase4;
    logic load_pc4, load_if_id4, load_id_ex4, load_ex_mem4, load_mem_wb4;
    logic flush_if_id4, flush_id_ex4, flush_ex_mem4;
    logic [3:0] stall_cycles4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_control #(.STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .imem_resp(imem_resp), .dmem_req(dmem_req),
        .mem_is_store(mem_is_store), .mem_indirect(mem_indirect), .dmem_resp(dmem_resp),
        .load_use(load_use), .branch_taken(branch_taken),
        .imem_read(imem_read), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .indir_phase(indir_phase), .load_pc(load_pc), .load_if_id(load_if_id),
        .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .stall_cycles(stall_cycles)
    );

    pipeline_control #(.STALL_CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .imem_resp(imem_resp), .dmem_req(dmem_req),
        .mem_is_store(mem_is_store), .mem_indirect(mem_indirect), .dmem_resp(dmem_resp),
        .load_use(load_use), .branch_taken(branch_taken),
        .imem_read(imem_read4), .dmem_read(dmem_read4), .dmem_write(dmem_write4),
        .indir_phase(indir_phase4), .load_pc(load_pc4), .load_if_id(load_if_id4),
        .load_id_ex(load_id_ex4), .load_ex_mem(load_ex_mem4), .load_mem_wb(load_mem_wb4),
        .flush_if_id(flush_if_id4), .flush_id_ex(flush_id_ex4), .flush_ex_mem(flush_ex_mem4),
        .stall_cycles(stall_cycles4)
    );

    // {imem_read,dmem_read,dmem_write,indir_phase, load_pc..load_mem_wb, flush_if_id..flush_ex_mem}
    logic [11:0] outs;
    assign outs = {imem_read, dmem_read, dmem_write, indir_phase,
                   load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                   flush_if_id, flush_id_ex, flush_ex_mem};
    logic [4:0] loads;
    assign loads = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};

    // {imem_resp, dmem_req, mem_is_store, mem_indirect, dmem_resp, load_use, branch_taken}
    typedef struct packed {
        logic [6:0]  in;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] v);
        {imem_resp, dmem_req, mem_is_store, mem_indirect, dmem_resp, load_use, branch_taken} = v;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(7'b0);
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(7'b0);

        vecs[0]  = '{7'b0000000, 12'b1000_00000_000};
        vecs[1]  = '{7'b1000000, 12'b0000_11111_000};
        vecs[2]  = '{7'b1000001, 12'b0000_11111_111};
        vecs[3]  = '{7'b1000010, 12'b0000_00111_010};
        vecs[4]  = '{7'b1000011, 12'b0000_11111_111};
        vecs[5]  = '{7'b1100000, 12'b0100_00000_000};
        vecs[6]  = '{7'b1110000, 12'b0010_00000_000};
        vecs[7]  = '{7'b1110100, 12'b0010_11111_000};
        vecs[8]  = '{7'b1100110, 12'b0100_00111_010};
        vecs[9]  = '{7'b1111100, 12'b0100_00000_000};
        vecs[10] = '{7'b0000001, 12'b1000_00000_000};
        vecs[11] = '{7'b1100101, 12'b0100_11111_111};

        // Reset behaviour: flushes asserted, nothing requested, counter cleared.
        drive(7'b1100011);
        @(negedge clk);
        chk("reset_outputs", 32'(outs), 32'(12'b0000_00000_111));
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("reset_stall_cnt", 32'(stall_cycles), 32'd0);
        reset = 1'b0;
        next_cycle();

        for (int i = 0; i < 12; i++) begin
            do_reset();
            drive(vecs[i].in);
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
            next_cycle();
        end

        // LDR: three stalled cycles, response on the fourth.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive({1'b1, 1'b1, 1'b0, 1'b0, (c == 3), 1'b0, 1'b0});
            @(negedge clk);
            chk($sformatf("ldr_dmem_read_c%0d", c), 32'(dmem_read), 32'd1);
            chk($sformatf("ldr_loads_c%0d", c), 32'(loads), (c == 3) ? 32'h1f : 32'h0);
            next_cycle();
        end
        drive(7'b1000000);
        @(negedge clk);
        chk("ldr_stall_cycles", 32'(stall_cycles), 32'd3);
        next_cycle();

        // LDI: pointer response at cycle 2, data response at cycle 5.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive({1'b1, 1'b1, 1'b0, 1'b1, (c == 2 || c == 5), 1'b0, 1'b0});
            @(negedge clk);
            chk($sformatf("ldi_indir_c%0d", c), 32'(indir_phase), (c >= 3) ? 32'd1 : 32'd0);
            chk($sformatf("ldi_rdwr_c%0d", c), 32'({dmem_read, dmem_write}), 32'b10);
            chk($sformatf("ldi_load_pc_c%0d", c), 32'(load_pc), (c == 5) ? 32'd1 : 32'd0);
            next_cycle();
        end
        drive(7'b1000000);
        @(negedge clk);
        chk("ldi_back_to_run", 32'(indir_phase), 32'd0);
        chk("ldi_stall_cycles", 32'(stall_cycles), 32'd5);
        next_cycle();

        // STI: pointer read then data write.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive({1'b1, 1'b1, 1'b1, 1'b1, (c == 1 || c == 3), 1'b0, 1'b0});
            @(negedge clk);
            chk($sformatf("sti_rdwr_c%0d", c), 32'({dmem_read, dmem_write}),
                (c >= 2) ? 32'b01 : 32'b10);
            next_cycle();
        end

        // Fetch completes while data access pending; no re-fetch, advance on dmem_resp.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive({(c == 0), 1'b1, 1'b0, 1'b0, (c == 3), 1'b0, 1'b0});
            @(negedge clk);
            chk($sformatf("ifheld_imem_read_c%0d", c), 32'(imem_read), 32'd0);
            chk($sformatf("ifheld_loads_c%0d", c), 32'(loads), (c == 3) ? 32'h1f : 32'h0);
            next_cycle();
        end
        drive(7'b0);
        @(negedge clk);
        chk("ifheld_cleared_imem_read", 32'(imem_read), 32'd1);
        chk("ifheld_cleared_load_pc", 32'(load_pc), 32'd0);
        next_cycle();

        // Counter saturation: 20 fetch-stall cycles.
        do_reset();
        drive(7'b0);
        repeat (20) next_cycle();
        @(negedge clk);
        chk("sat_w4", 32'(stall_cycles4), 32'd15);
        chk("nosat_w16", 32'(stall_cycles), 32'd20);
        next_cycle();

        // Reset while in the second indirect phase abandons the access.
        do_reset();
        drive(7'b1101100);
        next_cycle();
        drive(7'b1101000);
        @(negedge clk);
        chk("rst_ind2_before", 32'(indir_phase), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_ind2_during", 32'(outs), 32'(12'b0000_00000_111));
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ind2_after_indir", 32'(indir_phase), 32'd0);
        chk("rst_ind2_after_rd", 32'(dmem_read), 32'd1);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
